// File: rtl/nco_step_gen_pkg.sv
// Purpose : shared constants, FSM state type and semitone table for nco_step_gen.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package nco_step_gen_pkg;

  localparam int NOTE_OFFSET = 4;   // MIDI note 0 maps to table semitone 4
  localparam int SEMIS       = 12;  // semitones per octave
  localparam int TOP_OCT     = 10;  // octave holding the table's native pitch

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_LOOK,
    ST_INTERP,
    ST_SCALE,
    ST_DONE
  } state_t;

  // Steps for notes 116..127 at 16 bits; every other octave is derived from these.
  function automatic logic [15:0] base_val(input logic [3:0] idx);
    case (idx)
      4'd0:    base_val = 16'd13609;
      4'd1:    base_val = 16'd14418;
      4'd2:    base_val = 16'd15275;
      4'd3:    base_val = 16'd16184;
      4'd4:    base_val = 16'd17146;
      4'd5:    base_val = 16'd18165;
      4'd6:    base_val = 16'd19246;
      4'd7:    base_val = 16'd20390;
      4'd8:    base_val = 16'd21602;
      4'd9:    base_val = 16'd22887;
      4'd10:   base_val = 16'd24248;
      4'd11:   base_val = 16'd25690;
      default: base_val = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/nco_step_gen_base_rom.sv
// Purpose : 12-entry semitone table with two read ports (lo = semi, hi = next semi).
// Latency : 1 clock, registered outputs, only updates when i_ce is high.
// Backpr. : none; caller controls read timing through i_ce.
// Ports   : i_clk, i_rst (sync, active high), i_ce, i_semi (0..11),
//           o_lo / o_hi (STEP_W+1 bits, table values pre-scaled by 2^(STEP_W-16)).
module nco_step_gen_base_rom
  import nco_step_gen_pkg::*;
#(
  parameter int STEP_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic [3:0]        i_semi,
  output logic [STEP_W:0]   o_lo,
  output logic [STEP_W:0]   o_hi
);

  localparam int SH = STEP_W - 16;

  logic [16:0] w_lo16;
  logic [16:0] w_hi16;

  always_comb begin
    w_lo16 = {1'b0, base_val(i_semi)};
    // Above the last semitone the next entry is the first one an octave up.
    if (i_semi == 4'(SEMIS - 1)) begin
      w_hi16 = {base_val(4'd0), 1'b0};
    end else begin
      w_hi16 = {1'b0, base_val(i_semi + 4'd1)};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lo <= '0;
      o_hi <= '0;
    end else if (i_ce) begin
      o_lo <= (STEP_W + 1)'(w_lo16) << SH;
      o_hi <= (STEP_W + 1)'(w_hi16) << SH;
    end
  end

endmodule

// File: rtl/nco_step_gen.sv
// Purpose : MIDI note + fine tune -> NCO phase step, stored per voice with readback.
// Latency : o_out_valid oct+5 CE clocks after the accept edge (accept edge counted as 1).
// Backpr. : o_req_ready low while busy; requests are not queued, requester holds i_req_valid.
// Ports   : i_clk, i_rst (sync, active high), i_ce (global hold),
//           i_req_valid/o_req_ready + i_req_voice/i_req_note/i_req_fine request port,
//           o_out_valid pulse with o_out_voice/o_out_step, i_rd_voice -> o_rd_step readback.
module nco_step_gen
  import nco_step_gen_pkg::*;
#(
  parameter int VOICES  = 4,
  parameter int VOICE_W = 2,
  parameter int FRAC_W  = 8,
  parameter int STEP_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ce,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [VOICE_W-1:0] i_req_voice,
  input  logic [6:0]         i_req_note,
  input  logic [FRAC_W-1:0]  i_req_fine,
  output logic               o_out_valid,
  output logic [VOICE_W-1:0] o_out_voice,
  output logic [STEP_W-1:0]  o_out_step,
  input  logic [VOICE_W-1:0] i_rd_voice,
  output logic [STEP_W-1:0]  o_rd_step
);

  localparam int XW = STEP_W + 1;  // interpolation width, holds 2*BASE[0]

  state_t             r_state;
  logic [VOICE_W-1:0] r_voice;
  logic [FRAC_W-1:0]  r_fine;
  logic [7:0]         r_rem;
  logic [3:0]         r_oct;
  logic [XW-1:0]      r_x;
  logic [STEP_W-1:0]  r_step_reg [VOICES];

  logic               w_rom_en;
  logic [XW-1:0]      w_lo;
  logic [XW-1:0]      w_hi;
  logic [XW-1:0]      w_diff;
  logic [XW+FRAC_W-1:0] w_prod;
  logic [XW-1:0]      w_x_next;
  logic [3:0]         w_shift;
  logic [XW:0]        w_half;
  logic [XW:0]        w_sum;
  logic [STEP_W-1:0]  w_step;

  // After DIV, r_rem is the semitone; the ROM samples it in LOOK.
  assign w_rom_en = i_ce && (r_state == ST_LOOK);

  nco_step_gen_base_rom #(
    .STEP_W (STEP_W)
  ) u_rom (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_ce   (w_rom_en),
    .i_semi (r_rem[3:0]),
    .o_lo   (w_lo),
    .o_hi   (w_hi)
  );

  // Linear interpolation between neighbouring semitones, fraction truncated.
  always_comb begin
    w_diff   = w_hi - w_lo;
    w_prod   = (XW + FRAC_W)'(w_diff) * (XW + FRAC_W)'(r_fine);
    w_x_next = w_lo + XW'(w_prod >> FRAC_W);
  end

  // Octave fold: divide by 2^(10-oct), rounding half up.
  always_comb begin
    w_shift = 4'(TOP_OCT) - r_oct;
    w_half  = '0;
    if (w_shift != 4'd0) begin
      w_half = (XW + 1)'(1) << (w_shift - 4'd1);
    end
    w_sum  = {1'b0, r_x} + w_half;
    w_step = STEP_W'(w_sum >> w_shift);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      o_req_ready <= 1'b1;
      o_out_valid <= 1'b0;
      o_out_voice <= '0;
      o_out_step  <= '0;
      o_rd_step   <= '0;
      r_voice     <= '0;
      r_fine      <= '0;
      r_rem       <= '0;
      r_oct       <= '0;
      r_x         <= '0;
      for (int v = 0; v < VOICES; v++) begin
        r_step_reg[v] <= '0;
      end
    end else if (i_ce) begin
      o_out_valid <= 1'b0;
      // Read happens before any SCALE write lands, so a same-voice write shows next cycle.
      if (32'(i_rd_voice) < VOICES) begin
        o_rd_step <= r_step_reg[i_rd_voice];
      end else begin
        o_rd_step <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_voice     <= i_req_voice;
            r_fine      <= i_req_fine;
            r_rem       <= {1'b0, i_req_note} + 8'(NOTE_OFFSET);
            r_oct       <= '0;
            o_req_ready <= 1'b0;
            r_state     <= ST_DIV;
          end
        end
        ST_DIV: begin
          // Repeated subtraction: oct+1 cycles, leaves the semitone in r_rem.
          if (r_rem >= 8'(SEMIS)) begin
            r_rem <= r_rem - 8'(SEMIS);
            r_oct <= r_oct + 4'd1;
          end else begin
            r_state <= ST_LOOK;
          end
        end
        ST_LOOK: begin
          r_state <= ST_INTERP;
        end
        ST_INTERP: begin
          r_x     <= w_x_next;
          r_state <= ST_SCALE;
        end
        ST_SCALE: begin
          if (32'(r_voice) < VOICES) begin
            r_step_reg[r_voice] <= w_step;
          end
          o_out_step  <= w_step;
          o_out_voice <= r_voice;
          o_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          o_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          o_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_step_gen.sv
// Purpose : self-checking bench for nco_step_gen against an arithmetic reference model.
// Latency : n/a.
// Backpr. : holds requests until accepted, CE optionally randomised.
module tb_nco_step_gen;

  logic       i_clk;
  logic       i_rst;
  logic       i_ce;
  logic       i_req_valid;
  logic       o_req_ready;
  logic [1:0] i_req_voice;
  logic [6:0] i_req_note;
  logic [7:0] i_req_fine;
  logic       o_out_valid;
  logic [1:0] o_out_voice;
  logic [15:0] o_out_step;
  logic [1:0] i_rd_voice;
  logic [15:0] o_rd_step;

  int n_tests = 0;
  int n_fail  = 0;
  int model_reg [4];
  int base_tab [12] = '{13609, 14418, 15275, 16184, 17146, 18165,
                        19246, 20390, 21602, 22887, 24248, 25690};

  nco_step_gen #(
    .VOICES  (4),
    .VOICE_W (2),
    .FRAC_W  (8),
    .STEP_W  (16)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_ce        (i_ce),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_voice (i_req_voice),
    .i_req_note  (i_req_note),
    .i_req_fine  (i_req_fine),
    .o_out_valid (o_out_valid),
    .o_out_voice (o_out_voice),
    .o_out_step  (o_out_step),
    .i_rd_voice  (i_rd_voice),
    .o_rd_step   (o_rd_step)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_oct(input int note);
    return (note + 4) / 12;
  endfunction

  // Reference step straight from the pitch arithmetic.
  function automatic int model_step(input int note, input int fine);
    int n, semi, lo, hi, x, s;
    n    = note + 4;
    semi = n % 12;
    lo   = base_tab[semi];
    hi   = (semi == 11) ? 2 * base_tab[0] : base_tab[semi + 1];
    x    = lo + (((hi - lo) * fine) / 256);
    s    = 10 - n / 12;
    if (s == 0) return x;
    return (x + (1 << (s - 1))) / (1 << s);
  endfunction

  // Inputs change and outputs are sampled only at negedges; every task starts
  // and ends just after a negedge.
  task automatic run_req(input int v, input int note, input int fine, input bit rnd_ce);
    int  edges = 0;
    int  pulses = 0;
    int  got_step = -1;
    int  got_voice = -1;
    int  lat = -1;
    int  rd_old = -1;
    int  rd_new = -1;
    int  idle_cnt = 0;
    int  exp_s;
    bit  accepted = 0;
    bit  want_new = 0;
    bit  done = 0;
    bit  acc_now;
    bit  ce_now;
    exp_s = model_step(note, fine);
    i_req_valid = 1'b1;
    i_req_voice = 2'(v);
    i_req_note  = 7'(note);
    i_req_fine  = 8'(fine);
    i_rd_voice  = 2'(v);
    i_ce = rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      acc_now = !accepted && i_req_valid && o_req_ready && i_ce;
      ce_now  = i_ce;
      @(posedge i_clk);
      @(negedge i_clk);
      // Latency counts CE edges, the accept edge being the first.
      if (acc_now) begin
        accepted = 1'b1;
        edges = 1;
      end else if (accepted && ce_now) begin
        edges++;
      end
      if (ce_now) begin
        if (want_new) begin
          rd_new = o_rd_step;
          want_new = 1'b0;
        end else if (accepted && o_out_valid) begin
          pulses++;
          if (pulses == 1) begin
            got_step  = o_out_step;
            got_voice = o_out_voice;
            lat       = edges;
            rd_old    = o_rd_step;
            want_new  = 1'b1;
            i_req_valid = 1'b0;
          end
        end
        if (pulses > 0 && !want_new) idle_cnt++;
        if (idle_cnt >= 4) done = 1'b1;
      end
      // While busy the request fields must be ignored: scramble them.
      if (accepted && i_req_valid) begin
        i_req_voice = 2'($urandom_range(0, 3));
        i_req_note  = 7'($urandom_range(0, 127));
        i_req_fine  = 8'($urandom_range(0, 255));
      end
      i_ce = rnd_ce ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    i_req_valid = 1'b0;
    i_ce = 1'b1;
    chk($sformatf("done n%0d", note), int'(done), 1);
    chk($sformatf("pulses n%0d", note), pulses, 1);
    chk($sformatf("step n%0d f%0d", note, fine), got_step, exp_s);
    chk($sformatf("voice n%0d", note), got_voice, v);
    chk($sformatf("latency n%0d", note), lat, model_oct(note) + 5);
    chk($sformatf("rd_old v%0d", v), rd_old, model_reg[v]);
    model_reg[v] = exp_s;
    chk($sformatf("rd_new v%0d", v), rd_new, exp_s);
  endtask

  task automatic rd_chk(input int v, input int exp);
    i_rd_voice = 2'(v);
    i_ce = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk($sformatf("readback v%0d", v), int'(o_rd_step), exp);
  endtask

  initial begin
    int notes4 [4] = '{0, 48, 96, 127};
    int seen_pulse;
    for (int v = 0; v < 4; v++) model_reg[v] = 0;
    i_rst = 1'b1;
    i_ce = 1'b1;
    i_req_valid = 1'b0;
    i_req_voice = '0;
    i_req_note = '0;
    i_req_fine = '0;
    i_rd_voice = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset ready", int'(o_req_ready), 1);
    chk("reset out_valid", int'(o_out_valid), 0);
    chk("reset out_voice", int'(o_out_voice), 0);
    chk("reset out_step", int'(o_out_step), 0);
    chk("reset rd_step", int'(o_rd_step), 0);
    i_rst = 1'b0;

    // Directed points with hand-derived values.
    run_req(1, 69, 0, 1'b0);
    chk("note69 literal", model_reg[1], 901);
    rd_chk(1, 901);
    run_req(2, 69, 128, 1'b0);
    chk("note69 fine128 literal", model_reg[2], 928);
    run_req(3, 127, 0, 1'b0);
    chk("note127 literal", model_reg[3], 25690);

    // Full note sweep with no fine tune.
    for (int n = 0; n < 128; n++) begin
      run_req(n % 4, n, 0, 1'b0);
      if (n == 0)   chk("legacy note0", model_reg[0], 17);
      if (n == 60)  chk("legacy note60", model_reg[0], 536);
      if (n == 100) chk("legacy note100", model_reg[0], 5401);
    end

    // Random requests with CE toggling.
    for (int k = 0; k < 40; k++) begin
      run_req($urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 255), 1'b1);
    end

    // Back-to-back voices, then readback of all four.
    for (int v = 0; v < 4; v++) run_req(v, notes4[v], 0, 1'b0);
    rd_chk(0, 17);
    rd_chk(1, 268);
    rd_chk(2, model_step(96, 0));
    rd_chk(3, 25690);

    // Reset during the octave divide of note 127.
    i_req_valid = 1'b1;
    i_req_voice = 2'd0;
    i_req_note  = 7'd127;
    i_req_fine  = 8'd0;
    chk("pre-abort ready", int'(o_req_ready), 1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    chk("abort busy", int'(o_req_ready), 0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("abort ready", int'(o_req_ready), 1);
    chk("abort out_valid", int'(o_out_valid), 0);
    seen_pulse = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_out_valid) seen_pulse++;
    end
    chk("abort no pulse", seen_pulse, 0);
    for (int v = 0; v < 4; v++) model_reg[v] = 0;
    for (int v = 0; v < 4; v++) rd_chk(v, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
